// File: rtl/aes_byte_bridge.sv
// aes_byte_bridge: byte-serial front/back end for the AES core.
// Collects 16 input bytes into a block, pulses START for one cycle, waits
// for DONE, then streams the 128-bit result out one byte at a time.
// Optional feature macro: AES_BRIDGE_CBC_EN adds CBC chaining around the
// core (128-bit chain register, loaded from cfg_iv by iv_load).
// Without the macro the bridge is plain ECB and cfg_iv/iv_load are unused.
module aes_byte_bridge (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         cfg_encdec,
  input  logic [127:0] cfg_key,
  input  logic [127:0] cfg_iv,
  input  logic         iv_load,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [7:0]   m_data,
  output logic         busy,
  output logic         aes_start,
  output logic         aes_encdec,
  output logic [127:0] aes_key,
  output logic [127:0] aes_textin,
  input  logic         aes_done,
  input  logic [127:0] aes_textout
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    KICK  = 2'd1,
    WAITD = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [3:0]     cnt;
  logic [127:0]   blk;
  logic [127:0]   obuf;
  logic [127:0]   blk_full;
  logic [127:0]   textin_nx;
  logic [127:0]   obuf_nx;
  logic           in_hs, out_hs;

  assign in_hs    = s_valid & s_ready;
  assign out_hs   = m_valid & m_ready;
  assign blk_full = {blk[119:0], s_data};
  assign m_data   = obuf[127:120];

`ifdef AES_BRIDGE_CBC_EN
  logic [127:0] chain;

  // Encrypt folds the chain in before the core; decrypt folds it in after.
  assign textin_nx = cfg_encdec ? blk_full : (blk_full ^ chain);
  assign obuf_nx   = aes_encdec ? (aes_textout ^ chain) : aes_textout;

  // Chain register: IV load only at a block boundary, otherwise it tracks
  // the ciphertext of the block just processed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      chain <= '0;
    end else if (state == FILL && cnt == 4'd0 && iv_load) begin
      chain <= cfg_iv;
    end else if (state == WAITD && aes_done) begin
      chain <= aes_encdec ? aes_textin : aes_textout;
    end
  end
`else
  logic unused_cbc_cfg;

  assign unused_cbc_cfg = ^{cfg_iv, iv_load};
  assign textin_nx      = blk_full;
  assign obuf_nx        = aes_textout;
`endif

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= FILL;
    else       state <= state_nx;
  end

  // Next state and state-decoded handshake/control outputs (no path from
  // s_valid/m_ready into s_ready/m_valid/busy/aes_start).
  always_comb begin
    state_nx  = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    busy      = 1'b1;
    aes_start = 1'b0;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (in_hs && cnt == 4'd15) state_nx = KICK;
      end
      KICK: begin
        aes_start = 1'b1;
        state_nx  = WAITD;
      end
      WAITD: begin
        if (aes_done) state_nx = DRAIN;
      end
      DRAIN: begin
        m_valid = 1'b1;
        if (out_hs && cnt == 4'd15) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // Datapath: byte assembly, core operand capture, result shift-out.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt        <= '0;
      blk        <= '0;
      obuf       <= '0;
      aes_encdec <= 1'b0;
      aes_key    <= '0;
      aes_textin <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_hs) begin
            blk <= blk_full;
            if (cnt == 4'd15) begin
              cnt        <= '0;
              aes_encdec <= cfg_encdec;
              aes_key    <= cfg_key;
              aes_textin <= textin_nx;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        WAITD: begin
          if (aes_done) obuf <= obuf_nx;
        end
        DRAIN: begin
          if (out_hs) begin
            obuf <= {obuf[119:0], 8'h00};
            cnt  <= (cnt == 4'd15) ? 4'd0 : cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_byte_bridge.sv
// Self-checking bench for aes_byte_bridge. Contains a behavioural AES core
// (FIPS-197 cipher/inverse cipher) attached to the core ports, and a block-
// level reference model computing expected results from AES/CBC rules.
module tb_aes_byte_bridge;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         cfg_encdec = 1'b0;
  logic [127:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         iv_load = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [7:0]   s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [7:0]   m_data;
  logic         busy, aes_start, aes_encdec;
  logic [127:0] aes_key, aes_textin, aes_textout;
  logic         aes_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  aes_byte_bridge dut (
    .CLK(CLK), .nRST(nRST), .cfg_encdec(cfg_encdec), .cfg_key(cfg_key),
    .cfg_iv(cfg_iv), .iv_load(iv_load), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .aes_start(aes_start), .aes_encdec(aes_encdec),
    .aes_key(aes_key), .aes_textin(aes_textin), .aes_done(aes_done),
    .aes_textout(aes_textout)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural AES ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s, t;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gm(inv, 8'(x));
      end
      s = inv;
      t = inv;
      for (int k = 0; k < 4; k++) begin
        t = {t[6:0], t[7]};
        s ^= t;
      end
      s ^= 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [1407:0] kexp(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
    return r;
  endfunction

  function automatic logic [127:0] subb(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? isb[s[127-8*i -: 8]] : sb[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shrows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      if (!inv)
        o[127-32*c -: 32] = {gm(a0,8'h02)^gm(a1,8'h03)^a2^a3, a0^gm(a1,8'h02)^gm(a2,8'h03)^a3,
                             a0^a1^gm(a2,8'h02)^gm(a3,8'h03), gm(a0,8'h03)^a1^a2^gm(a3,8'h02)};
      else
        o[127-32*c -: 32] = {gm(a0,8'h0e)^gm(a1,8'h0b)^gm(a2,8'h0d)^gm(a3,8'h09),
                             gm(a0,8'h09)^gm(a1,8'h0e)^gm(a2,8'h0b)^gm(a3,8'h0d),
                             gm(a0,8'h0d)^gm(a1,8'h09)^gm(a2,8'h0e)^gm(a3,8'h0b),
                             gm(a0,8'h0b)^gm(a1,8'h0d)^gm(a2,8'h09)^gm(a3,8'h0e)};
    end
    return o;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [1407:0] kx = kexp(key);
    logic [127:0] s = pt ^ kx[1407 -: 128];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      s = shrows(subb(s, 1'b0), 1'b0);
      if (rnd < 10) s = mixc(s, 1'b0);
      s ^= kx[1407-128*rnd -: 128];
    end
    return s;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] key, input logic [127:0] ct);
    logic [1407:0] kx = kexp(key);
    logic [127:0] s = ct ^ kx[127:0];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      s = subb(shrows(s, 1'b1), 1'b1);
      s ^= kx[1407-128*rnd -: 128];
      if (rnd > 0) s = mixc(s, 1'b1);
    end
    return s;
  endfunction

  // ---------------- core model on the core ports ----------------
  int core_lat = 3;
  logic spur_done = 1'b0;
  int cd = 0;
  logic [127:0] cres;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cd = 0;
      aes_done <= 1'b0;
      aes_textout <= '0;
    end else begin
      aes_done <= spur_done;
      aes_textout <= {$urandom(), $urandom(), $urandom(), $urandom()};
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          aes_done <= 1'b1;
          aes_textout <= cres;
        end
      end
      if (aes_start) begin
        cres = aes_encdec ? aes_dec(aes_key, aes_textin) : aes_enc(aes_key, aes_textin);
        cd = core_lat;
      end
    end
  end

  // ---------------- block-level reference (ECB or CBC rules) ----------------
  logic [127:0] ref_chain = '0;

  function automatic logic [127:0] model_block(input logic ed, input logic [127:0] k,
                                               input logic [127:0] b);
    logic [127:0] r;
`ifdef AES_BRIDGE_CBC_EN
    if (!ed) begin
      r = aes_enc(k, b ^ ref_chain);
      ref_chain = r;
    end else begin
      r = aes_dec(k, b) ^ ref_chain;
      ref_chain = b;
    end
`else
    r = ed ? aes_dec(k, b) : aes_enc(k, b);
`endif
    return r;
  endfunction

  // ---------------- monitor (samples on falling edge) ----------------
  logic [7:0] out_q [$];
  int in_cnt = 0, starts = 0, start_bad = 0, stall_bad = 0, overlap_bad = 0;
  int b16_cyc = 0, start_cyc = 0, done_cyc = 0, mv_cyc = 0, sr_cyc = 0;
  logic prev_stall = 1'b0, prev_mv = 1'b0, prev_sr = 1'b1;
  logic [7:0] stall_d = '0;

  always @(negedge CLK) begin
    if (!nRST) begin
      prev_stall = 1'b0; prev_mv = 1'b0; prev_sr = 1'b1;
    end else begin
      if (aes_start) begin
        starts++;
        start_cyc = cyc;
        if (in_cnt == 0 || in_cnt % 16 != 0) start_bad++;
      end
      if (s_valid && s_ready) begin
        in_cnt++;
        if (in_cnt % 16 == 0) b16_cyc = cyc;
      end
      if (aes_done && busy && !m_valid && !aes_start) done_cyc = cyc;
      if (m_valid && !prev_mv) mv_cyc = cyc;
      if (s_ready && !prev_sr) sr_cyc = cyc;
      if (prev_stall && (!m_valid || m_data !== stall_d)) stall_bad++;
      if (m_valid && s_ready) overlap_bad++;
      if (m_valid && m_ready) out_q.push_back(m_data);
      prev_stall = m_valid && !m_ready;
      stall_d = m_data;
      prev_mv = m_valid;
      prev_sr = s_ready;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_block(input logic [127:0] b, input int gap_at, input int gap_len);
    int t;
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        s_valid = 1'b0;
        repeat (gap_len) @(posedge CLK);
        #1;
      end
      s_valid = 1'b1;
      s_data = b[127-8*i -: 8];
      t = 0;
      while (!s_ready && t < 200) begin
        @(posedge CLK); #1; t++;
      end
      if (!s_ready) begin
        total++; bad++;
        $display("FAIL send_timeout byte=%0d s_ready=%b want 1", i, s_ready);
        s_valid = 1'b0;
        return;
      end
      @(posedge CLK); #1;
    end
    s_valid = 1'b0;
    s_data = 8'hxx;
  endtask

  task automatic recv_block(input int mode, output logic [127:0] got);
    int t = 0;
    got = '0;
    while (out_q.size() < 16 && t < 3000) begin
      case (mode)
        1: m_ready = (t % 4 == 0) || (t % 4 == 3);
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
      @(posedge CLK); #1; t++;
    end
    m_ready = 1'b1;
    if (out_q.size() < 16) begin
      total++; bad++;
      $display("FAIL recv_timeout bytes=%0d want 16", out_q.size());
      out_q.delete();
      return;
    end
    repeat (4) @(posedge CLK);
    #1;
    total++;
    if (out_q.size() != 16) begin
      bad++;
      $display("FAIL byte_count got=%0d want 16", out_q.size());
    end
    for (int i = 0; i < 16; i++) got[127-8*i -: 8] = out_q.pop_front();
    out_q.delete();
  endtask

  task automatic do_block(input logic ed, input logic [127:0] k, input logic [127:0] b,
                          input int gap_at, input int gap_len, input int mode,
                          output logic [127:0] got);
    cfg_encdec = ed;
    cfg_key = k;
    send_block(b, gap_at, gap_len);
    recv_block(mode, got);
  endtask

  task automatic load_iv(input logic [127:0] iv);
    cfg_iv = iv;
    iv_load = 1'b1;
    @(posedge CLK); #1;
    iv_load = 1'b0;
`ifdef AES_BRIDGE_CBC_EN
    ref_chain = iv;
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (s_ready !== 1'b1)    begin bad++; $display("FAIL rst_s_ready got=%b want 1", s_ready); end
    total++; if (m_valid !== 1'b0)    begin bad++; $display("FAIL rst_m_valid got=%b want 0", m_valid); end
    total++; if (m_data !== 8'h00)    begin bad++; $display("FAIL rst_m_data got=%h want 00", m_data); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL rst_busy got=%b want 0", busy); end
    total++; if (aes_start !== 1'b0)  begin bad++; $display("FAIL rst_aes_start got=%b want 0", aes_start); end
    total++; if (aes_encdec !== 1'b0) begin bad++; $display("FAIL rst_aes_encdec got=%b want 0", aes_encdec); end
    total++; if (aes_key !== '0)      begin bad++; $display("FAIL rst_aes_key got=%h want 0", aes_key); end
    total++; if (aes_textin !== '0)   begin bad++; $display("FAIL rst_aes_textin got=%h want 0", aes_textin); end
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_ecb_encrypt();
    logic [127:0] got, exp;
    int st0;
    load_iv('0);
    core_lat = 5;
    st0 = starts;
    exp = model_block(1'b0, KEY0, PT0);
    do_block(1'b0, KEY0, PT0, -1, 0, 0, got);
    total++; if (got !== CT0) begin bad++; $display("FAIL ecb_enc_vector got=%h want %h", got, CT0); end
    total++; if (got !== exp) begin bad++; $display("FAIL ecb_enc_model got=%h want %h", got, exp); end
    total++; if (starts - st0 != 1) begin bad++; $display("FAIL enc_start_count got=%0d want 1", starts - st0); end
    total++; if (start_cyc != b16_cyc + 1) begin bad++; $display("FAIL start_latency got=%0d want 1", start_cyc - b16_cyc); end
    total++; if (mv_cyc != done_cyc + 1) begin bad++; $display("FAIL mvalid_latency got=%0d want 1", mv_cyc - done_cyc); end
    total++; if (sr_cyc != done_cyc + 17) begin bad++; $display("FAIL sready_return got=%0d want 17", sr_cyc - done_cyc); end
    total++; if (mv_cyc != start_cyc + core_lat + 2) begin bad++; $display("FAIL block_overhead got=%0d want %0d", mv_cyc - start_cyc, core_lat + 2); end
  endtask

  task automatic test_ecb_decrypt();
    logic [127:0] got, exp;
    load_iv('0);
    core_lat = 2;
    exp = model_block(1'b1, KEY0, CT0);
    do_block(1'b1, KEY0, CT0, -1, 0, 0, got);
    total++; if (got !== PT0) begin bad++; $display("FAIL ecb_dec_vector got=%h want %h", got, PT0); end
    total++; if (got !== exp) begin bad++; $display("FAIL ecb_dec_model got=%h want %h", got, exp); end
  endtask

  task automatic test_backpressure();
    logic [127:0] got, exp, k, b;
    int sb0, ob0;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    sb0 = stall_bad; ob0 = overlap_bad;
    core_lat = 4;
    exp = model_block(1'b0, k, b);
    do_block(1'b0, k, b, -1, 0, 1, got);
    total++; if (got !== exp) begin bad++; $display("FAIL bp_data got=%h want %h", got, exp); end
    total++; if (stall_bad != sb0) begin bad++; $display("FAIL bp_stall_stable changes=%0d want 0", stall_bad - sb0); end
    total++; if (overlap_bad != ob0) begin bad++; $display("FAIL bp_sready_overlap cycles=%0d want 0", overlap_bad - ob0); end
  endtask

  task automatic test_input_gaps();
    logic [127:0] got, exp;
    int st0, sb0;
    load_iv('0);
    st0 = starts; sb0 = start_bad;
    core_lat = 3;
    exp = model_block(1'b0, KEY0, PT0);
    do_block(1'b0, KEY0, PT0, 7, 3, 0, got);
    total++; if (got !== CT0) begin bad++; $display("FAIL gap_vector got=%h want %h", got, CT0); end
    total++; if (got !== exp) begin bad++; $display("FAIL gap_model got=%h want %h", got, exp); end
    total++; if (start_bad != sb0) begin bad++; $display("FAIL gap_early_start count=%0d want 0", start_bad - sb0); end
    total++; if (starts - st0 != 1) begin bad++; $display("FAIL gap_start_count got=%0d want 1", starts - st0); end
  endtask

  task automatic test_spurious_done();
    logic [127:0] got, exp, k, b;
    spur_done = 1'b1;
    @(posedge CLK); #1;
    spur_done = 1'b0;
    @(posedge CLK); #1;
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL spur_busy got=%b want 0", busy); end
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL spur_m_valid got=%b want 0", m_valid); end
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp = model_block(1'b1, k, b);
    do_block(1'b1, k, b, -1, 0, 0, got);
    total++; if (got !== exp) begin bad++; $display("FAIL spur_next_block got=%h want %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got, exp;
    core_lat = 12;
    cfg_encdec = 1'b0;
    cfg_key = KEY0;
    send_block({$urandom(), $urandom(), $urandom(), $urandom()}, -1, 0);
    repeat (3) @(posedge CLK);
    #1;
    total++; if (busy !== 1'b1 || m_valid !== 1'b0) begin bad++; $display("FAIL mid_in_wait busy=%b m_valid=%b want 1/0", busy, m_valid); end
    nRST = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0)   begin bad++; $display("FAIL mid_rst_m_valid got=%b want 0", m_valid); end
    total++; if (s_ready !== 1'b1)   begin bad++; $display("FAIL mid_rst_s_ready got=%b want 1", s_ready); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL mid_rst_busy got=%b want 0", busy); end
    total++; if (aes_textin !== '0)  begin bad++; $display("FAIL mid_rst_textin got=%h want 0", aes_textin); end
    ref_chain = '0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    out_q.delete();
    core_lat = 4;
    @(posedge CLK); #1;
    exp = model_block(1'b0, KEY0, PT0);
    do_block(1'b0, KEY0, PT0, -1, 0, 0, got);
    total++; if (got !== CT0) begin bad++; $display("FAIL mid_rst_next got=%h want %h", got, CT0); end
    total++; if (got !== exp) begin bad++; $display("FAIL mid_rst_model got=%h want %h", got, exp); end
  endtask

`ifdef AES_BRIDGE_CBC_EN
  task automatic test_cbc();
    logic [127:0] k, p1, p2, c1, c2, d1, d2, e1, e2;
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    p1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    p2 = {$urandom(), $urandom(), $urandom(), $urandom()};
    core_lat = 3;
    load_iv(KEY0);
    e1 = model_block(1'b0, k, p1);
    do_block(1'b0, k, p1, -1, 0, 0, c1);
    e2 = model_block(1'b0, k, p2);
    do_block(1'b0, k, p2, -1, 0, 2, c2);
    total++; if (c1 !== e1) begin bad++; $display("FAIL cbc_c1 got=%h want %h", c1, e1); end
    total++; if (c2 !== e2) begin bad++; $display("FAIL cbc_c2 got=%h want %h", c2, e2); end
    total++; if (c2 === aes_enc(k, p2)) begin bad++; $display("FAIL cbc_c2_is_ecb got=%h want anything else", c2); end
    load_iv(KEY0);
    e1 = model_block(1'b1, k, c1);
    do_block(1'b1, k, c1, -1, 0, 0, d1);
    e2 = model_block(1'b1, k, c2);
    do_block(1'b1, k, c2, 5, 2, 1, d2);
    total++; if (d1 !== p1) begin bad++; $display("FAIL cbc_p1 got=%h want %h", d1, p1); end
    total++; if (d2 !== p2) begin bad++; $display("FAIL cbc_p2 got=%h want %h", d2, p2); end
    total++; if (d2 !== e2) begin bad++; $display("FAIL cbc_p2_model got=%h want %h", d2, e2); end
  endtask
`else
  task automatic test_iv_ignored();
    logic [127:0] got;
    load_iv({$urandom(), $urandom(), $urandom(), 32'h1});
    core_lat = 3;
    do_block(1'b0, KEY0, PT0, -1, 0, 0, got);
    total++; if (got !== CT0) begin bad++; $display("FAIL iv_ignored got=%h want %h", got, CT0); end
  endtask
`endif

  task automatic test_random();
    logic [127:0] got, exp, k, b;
    logic ed;
    int gap, gl, mode, sb0, ob0;
    sb0 = stall_bad; ob0 = overlap_bad;
    for (int n = 0; n < 8; n++) begin
      ed = 1'($urandom_range(0, 1));
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      b = {$urandom(), $urandom(), $urandom(), $urandom()};
      gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : -1;
      gl = int'($urandom_range(1, 4));
      mode = int'($urandom_range(0, 2));
      core_lat = int'($urandom_range(1, 8));
      if ($urandom_range(0, 3) == 0) load_iv({$urandom(), $urandom(), $urandom(), $urandom()});
      exp = model_block(ed, k, b);
      do_block(ed, k, b, gap, gl, mode, got);
      total++; if (got !== exp) begin bad++; $display("FAIL rand_%0d ed=%b got=%h want %h", n, ed, got, exp); end
    end
    total++; if (stall_bad != sb0) begin bad++; $display("FAIL rand_stall_stable changes=%0d want 0", stall_bad - sb0); end
    total++; if (overlap_bad != ob0) begin bad++; $display("FAIL rand_overlap cycles=%0d want 0", overlap_bad - ob0); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] got, exp, b;
    core_lat = 1;
    for (int n = 0; n < 3; n++) begin
      b = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp = model_block(1'b0, KEY0, b);
      do_block(1'b0, KEY0, b, -1, 0, 0, got);
      total++; if (got !== exp) begin bad++; $display("FAIL b2b_%0d got=%h want %h", n, got, exp); end
      total++; if (sr_cyc != done_cyc + 17) begin bad++; $display("FAIL b2b_sready_%0d got=%0d want 17", n, sr_cyc - done_cyc); end
      total++; if (mv_cyc != start_cyc + 3) begin bad++; $display("FAIL b2b_overhead_%0d got=%0d want 3", n, mv_cyc - start_cyc); end
    end
  endtask

  initial begin
    init_sbox();
    test_reset();
    test_ecb_encrypt();
    test_ecb_decrypt();
    test_backpressure();
    test_input_gaps();
    test_spurious_done();
    test_reset_mid();
`ifdef AES_BRIDGE_CBC_EN
    test_cbc();
`else
    test_iv_ignored();
`endif
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_byte_bridge.md
# aes_byte_bridge

Byte-serial front end and back end for the AES core (`aes_top`).
- Assembles 16 incoming bytes into a 128-bit block and launches the core with a one-cycle `START`.
- Waits for `DONE`, then serializes the 128-bit result as 16 outgoing bytes.
- Sits between the system byte streams and the core's `START`/`TEXTIN`/`TEXTOUT`/`DONE` ports.
- Optionally adds CBC chaining around the core.

## Interface
Parameters: none.

Ports:
- `CLK`  in  1  clock; all logic on the rising edge
- `nRST`  in  1  reset, asynchronous, active-low
- `cfg_encdec`  in  1  0: encrypt, 1: decrypt; sampled when the 16th input byte is accepted
- `cfg_key`  in  128  key; sampled together with `cfg_encdec`
- `cfg_iv`  in  128  CBC initial vector (ignored without the macro)
- `iv_load`  in  1  pulse: chain register <= `cfg_iv` (ignored without the macro)
- `s_valid`  in  1  input byte valid
- `s_ready`  out  1  bridge accepts an input byte
- `s_data`  in  8  input byte; first byte accepted maps to block bits [127:120]
- `m_valid`  out  1  output byte valid
- `m_ready`  in  1  downstream accepts an output byte
- `m_data`  out  8  output byte; first byte sent is result bits [127:120]
- `busy`  out  1  high in every state except FILL
- `aes_start`  out  1  to core `START`
- `aes_encdec`  out  1  to core `ENCDEC`
- `aes_key`  out  128  to core `KEY`
- `aes_textin`  out  128  to core `TEXTIN`
- `aes_done`  in  1  from core `DONE`
- `aes_textout`  in  128  from core `TEXTOUT`; valid in the cycle `aes_done`=1

## Operation
FSM has four states: FILL, KICK, WAIT, DRAIN. The reset state is FILL.

- **FILL**
  - `s_ready`=1.
  - On each `s_valid && s_ready`: `blk` <= {`blk`[119:0], `s_data`} and byte counter `cnt`++ (4-bit).
  - When the 16th byte is accepted (`cnt`==15), go to KICK in the same edge:
    - `cnt` <= 0
    - `aes_encdec` <= `cfg_encdec`
    - `aes_key` <= `cfg_key`
    - `aes_textin` <= assembled block (with CBC: see Configuration)
- **KICK**
  - `aes_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - Holds `aes_textin`, `aes_key` and `aes_encdec` stable.
  - On `aes_done`=1: `obuf` <= `aes_textout` (with CBC: see Configuration), then go to DRAIN.
- **DRAIN**
  - `m_valid`=1, `m_data`=`obuf`[127:120].
  - On each `m_ready` handshake: `obuf` shifts left by 8 and `cnt`++.
  - On the 16th handshake: `cnt` <= 0, go to FILL.
- `aes_done` in any state other than WAIT is ignored.
- `s_valid` outside FILL is ignored (`s_ready`=0); there is no input/output overlap.
- `iv_load` is honoured only in FILL with `cnt`==0; ignored elsewhere.
- Reset, including mid-operation: state FILL, `cnt`=0, `blk`/`obuf`/chain=0.
  - Outputs: `s_ready`=1, `m_valid`=0, `m_data`=0, `busy`=0, `aes_start`=0, `aes_encdec`=0, `aes_key`=0, `aes_textin`=0.
  - The core shares `nRST`, so no stale `DONE` survives reset.

## Timing
- `s_ready`, `m_valid`, `busy`, `aes_start` are decoded from registered state only; no combinational path from `s_valid`/`m_ready`.
- 16th input byte at edge N -> `aes_start`=1 in cycle N+1 -> WAIT from N+2.
- `aes_done` at edge D -> `m_valid`=1 from cycle D+1.
- With `m_ready` held high, the last byte goes out at D+16 and `s_ready`=1 at D+17.
- Back-to-back streaming: one byte per cycle on each side; total block overhead is 2 cycles plus core latency.
- `m_valid` stays high and `m_data` stays stable while `m_ready`=0.

## Configuration
- `AES_BRIDGE_CBC_EN` defined: CBC chaining with a 128-bit `chain` register.
  - Encrypt:
    - `aes_textin` = `blk` ^ `chain`.
    - On `aes_done`: `obuf` = `chain` = `aes_textout`.
  - Decrypt:
    - `aes_textin` = `blk`.
    - On `aes_done`: `obuf` = `aes_textout` ^ `chain`, and `chain` <= the ciphertext held in `aes_textin`.
- Undefined: ECB.
  - No `chain` register; `cfg_iv` and `iv_load` are unused.
  - `aes_textin` = `blk`, `obuf` = `aes_textout`.

## Test plan
- **ECB encrypt**
  - Stimulus: key 000102…0f, input bytes 00 11 22 … ff with the core attached.
  - Required: output bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
- **ECB decrypt**
  - Stimulus: same key, ciphertext 69c4…c55a.
  - Required: output 00 11 … ff.
- **Backpressure**
  - Stimulus: `m_ready` toggling 1-0-0-1 during DRAIN.
  - Required: `m_data` stable while stalled; exactly 16 bytes out; `s_ready` low until the last byte.
- **Input gaps**
  - Stimulus: `s_valid` low for 3 cycles between bytes 7 and 8.
  - Required: `aes_start` only after the 16th byte; same ciphertext as ECB encrypt.
- **Reset mid-operation**
  - Stimulus: `nRST` pulse during WAIT.
  - Required: `m_valid`=0, `s_ready`=1, `busy`=0 immediately; the next full block encrypts correctly.
- **CBC (`AES_BRIDGE_CBC_EN`)**
  - Stimulus: `iv_load` with IV 000102…0f, encrypt two blocks, then reload the IV and decrypt both ciphertexts.
  - Required: the original 32 bytes are recovered, and block 2's ciphertext differs from its ECB ciphertext.
